// File: rtl/ram_line_responder.sv
// Line-granular backing store answering the cache's byte-serial RAM bus.
// Whole-line reads and writes, one byte per ack, after a fixed access latency.
module ram_line_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 12,
    parameter int unsigned RAM_WORD_WIDTH = 8,
    parameter int unsigned BYTES_PER_LINE = 16,
    parameter int unsigned LATENCY        = 2
) (
    input  logic                      ram_clk,
    input  logic                      rst,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic                      ram_avalid,
    input  logic                      ram_rnw,
    input  logic [RAM_WORD_WIDTH-1:0] ram_wdata,
    output logic [RAM_WORD_WIDTH-1:0] ram_rdata,
    output logic                      ram_ack,
    output logic                      busy
);

    localparam int unsigned BEAT_W = $clog2(BYTES_PER_LINE);
    localparam int unsigned MEM_AW = RAM_ADDR_WIDTH + BEAT_W;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BYTES_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_t;

    state_t                    state;
    logic [RAM_ADDR_WIDTH-1:0] addr_q;
    logic                      rnw_q;
    logic [3:0]                lat_cnt;
    logic [BEAT_W-1:0]         beat;
    logic [BEAT_W-1:0]         ack_beat;

    logic [RAM_WORD_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge ram_clk) begin
        if (!rst) begin
            state     <= StIdle;
            addr_q    <= '0;
            rnw_q     <= 1'b0;
            lat_cnt   <= '0;
            beat      <= '0;
            ack_beat  <= '0;
            ram_ack   <= 1'b0;
            ram_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            ram_ack   <= 1'b0;
            ram_rdata <= '0;
            unique case (state)
                StIdle: begin
                    if (ram_avalid) begin
                        addr_q  <= ram_addr;
                        rnw_q   <= ram_rnw;
                        lat_cnt <= '0;
                        beat    <= '0;
                        busy    <= 1'b1;
                        state   <= (LATENCY == 0) ? StXfer : StWait;
                    end
                end
                StWait: begin
                    if (!ram_avalid) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (lat_cnt == LAT_LAST) begin
                        state <= StXfer;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                StXfer: begin
                    if (!ram_avalid) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        ram_ack   <= 1'b1;
                        ram_rdata <= rnw_q ? mem[{addr_q, beat}] : '0;
                        ack_beat  <= beat;
                        // Last beat parks the counter; it never rolls into the next line.
                        if (beat == BEAT_LAST) begin
                            state <= StDone;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (!ram_avalid) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Write lands at the edge closing the ack cycle; a withdrawn request writes nothing.
    always_ff @(posedge ram_clk) begin
        if (rst && ram_ack && !rnw_q && ram_avalid) begin
            mem[{addr_q, ack_beat}] <= ram_wdata;
        end
    end

endmodule
